// File: rtl/un_striping_sched_pkg.sv
`default_nettype none
// ============================================================================
// un_striping_sched_pkg
// Shared defaults and scheduler state encoding for the two-lane un-striper.
// Revision: 1.0
// ============================================================================
package un_striping_sched_pkg;

   localparam int c_DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND_L0 = 2'd1,
      ST_SEND_L1 = 2'd2
   } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/un_striping_sched_lane_fifo.sv
`default_nettype none
// ============================================================================
// un_striping_sched_lane_fifo
// Per-lane skew FIFO with flush; ovf_o marks a push dropped on a full FIFO.
// Revision: 1.0
// ============================================================================
module un_striping_sched_lane_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] head_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              ovf_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              w_do_pop;
   logic              w_do_push;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign head_o    = mem_q[rd_ptr_q];
   assign w_do_pop  = pop_i & ~empty_o & ~flush_i;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);
   assign ovf_o     = push_i & ~flush_i & full_o & ~w_do_pop;

   always_ff @(posedge clk_2f) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_2f) begin
      if (w_do_push && !reset) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/un_striping_sched.sv
`default_nettype none
// ============================================================================
// un_striping_sched
// Rebuilds one stream from two skewed lanes by strict lane_0/lane_1 alternation.
// Revision: 1.0
// ============================================================================
module un_striping_sched
   import un_striping_sched_pkg::*;
#(
   parameter int DATA_W    = c_DATA_W_DEFAULT,
   parameter int DEPTH     = 4,
   parameter int MAX_STALL = 8
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              valid_0,
   input  logic [DATA_W-1:0] lane_0,
   input  logic              valid_1,
   input  logic [DATA_W-1:0] lane_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              next_lane,
   output logic              skew_err,
   output logic              overflow_err
);

   localparam int SW = $clog2(MAX_STALL + 1);

   sched_state_e      state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic [SW-1:0]     stall_q, stall_d;
   logic              skew_q, skew_d;
   logic              ovf_q, ovf_d;

   logic [1:0]        w_pop;
   logic              w_flush;
   logic              w_sel;
   logic [1:0]        w_empty;
   logic [1:0]        w_full;
   logic [1:0]        w_ovf;
   logic [DATA_W-1:0] w_head [2];

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_lane
      un_striping_sched_lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk_2f  (clk_2f),
         .reset   (reset),
         .push_i  ((gi == 0) ? valid_0 : valid_1),
         .wdata_i ((gi == 0) ? lane_0  : lane_1),
         .pop_i   (w_pop[gi]),
         .flush_i (w_flush),
         .head_o  (w_head[gi]),
         .empty_o (w_empty[gi]),
         .full_o  (w_full[gi]),
         .ovf_o   (w_ovf[gi])
      );
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = 1'b0;
      stall_d = stall_q;
      skew_d  = 1'b0;
      ovf_d   = ovf_q | (|(w_ovf & w_full));
      w_pop   = 2'b00;
      w_flush = 1'b0;
      w_sel   = (state_q == ST_SEND_L1);
      unique case (state_q)
         ST_IDLE: begin
            stall_d = '0;
            if (!w_empty[0]) begin
               state_d = ST_SEND_L0;
            end
         end
         ST_SEND_L0, ST_SEND_L1: begin
            if (!w_empty[w_sel]) begin
               w_pop[w_sel] = 1'b1;
               data_d       = w_head[w_sel];
               valid_d      = 1'b1;
               stall_d      = '0;
               state_d      = w_sel ? ST_SEND_L0 : ST_SEND_L1;
            end else if (!w_empty[~w_sel]) begin
               // Only a waiting word on the other lane counts as skew.
               if (stall_q == SW'(MAX_STALL - 1)) begin
                  skew_d  = 1'b1;
                  w_flush = 1'b1;
                  stall_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  stall_d = stall_q + SW'(1);
               end
            end else begin
               stall_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         stall_q <= '0;
         skew_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
         skew_q  <= skew_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_out     = data_q;
   assign valid_out    = valid_q;
   assign next_lane    = (state_q == ST_SEND_L1);
   assign skew_err     = skew_q;
   assign overflow_err = ovf_q;

endmodule
`default_nettype wire
